best_arr_sender: RTL

// - Output stage after the main search FSM; reads the per-query best-leaf-index RAM once per send request.
// - Walks the RAM in blocked output order and streams each DATA_WIDTH index into the output FIFO.
// - The FIFO drives io_out[29:19] data and io_out[30] not-empty across to io_clk.

---
 rtl/fann_pkg.sv | 31 +++
 rtl/best_arr_sender_if.sv | 25 ++
 rtl/best_arr_sender_addr_gen.sv | 60 ++++++
 rtl/best_arr_sender.sv | 84 ++++++++
 4 files changed

// File: rtl/fann_pkg.sv
// Shared sizing constants and types for the best-index output path.
package fann_pkg;

    localparam int DATA_WIDTH = 11;
    localparam int ROW_SIZE   = 26;
    localparam int COL_SIZE   = 19;
    localparam int BLOCKING   = 4;
    localparam int NUM_QUERYS = ROW_SIZE * COL_SIZE;
    localparam int ADDR_WIDTH = $clog2(NUM_QUERYS);

    localparam int HALF_ROW = ROW_SIZE / 2;
    localparam int NXB      = (HALF_ROW + BLOCKING - 1) / BLOCKING;
    localparam int LAST_W   = HALF_ROW - (NXB - 1) * BLOCKING;

    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int X_W  = cnt_width(NXB);
    localparam int Y_W  = cnt_width(COL_SIZE);
    localparam int XI_W = cnt_width(BLOCKING);

    typedef logic [DATA_WIDTH-1:0] idx_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sender_state_t;

endpackage

// File: rtl/best_arr_sender_if.sv
// Start/status, RAM read port and output-FIFO write port of the best-index sender.
interface best_arr_sender_if;
    import fann_pkg::*;

    logic                  send_best_arr;
    logic                  ram_csb;
    logic [ADDR_WIDTH-1:0] ram_addr;
    idx_t                  ram_rdata;
    logic                  out_fifo_wenq;
    idx_t                  out_fifo_wdata;
    logic                  out_fifo_wfull_n;
    logic                  busy;
    logic                  done;

    modport master (
        input  send_best_arr, ram_rdata, out_fifo_wfull_n,
        output ram_csb, ram_addr, out_fifo_wenq, out_fifo_wdata, busy, done
    );

    modport slave (
        output send_best_arr, ram_rdata, out_fifo_wfull_n,
        input  ram_csb, ram_addr, out_fifo_wenq, out_fifo_wdata, busy, done
    );

endinterface

// File: rtl/best_arr_sender_addr_gen.sv
// Blocked-order RAM address walker: px, x-block, row y, column-in-block xi.
// Counters wrap back to zero after the final address, ready for the next pass.
module blocked_addr_gen
    import fann_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  step,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last
);
    localparam int SW = ADDR_WIDTH + 1;

    logic            px;
    logic [X_W-1:0]  x;
    logic [Y_W-1:0]  y;
    logic [XI_W-1:0] xi;
    logic [XI_W-1:0] xi_max;
    logic            xi_end, y_end, x_end;
    logic [SW-1:0]   sum;

    // The last x-block is narrower when half a row is not a multiple of BLOCKING.
    always_comb begin
        x_end  = (x == X_W'(NXB - 1));
        xi_max = x_end ? XI_W'(LAST_W - 1) : XI_W'(BLOCKING - 1);
        xi_end = (xi == xi_max);
        y_end  = (y == Y_W'(COL_SIZE - 1));
        last   = px && x_end && y_end && xi_end;
        sum    = SW'(px) * SW'(HALF_ROW) + SW'(y) * SW'(ROW_SIZE)
               + SW'(x) * SW'(BLOCKING) + SW'(xi);
        addr   = ADDR_WIDTH'(sum);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            px <= 1'b0;
            x  <= '0;
            y  <= '0;
            xi <= '0;
        end else if (step) begin
            if (!xi_end) begin
                xi <= xi + XI_W'(1);
            end else begin
                xi <= '0;
                if (!y_end) begin
                    y <= y + Y_W'(1);
                end else begin
                    y <= '0;
                    if (!x_end) begin
                        x <= x + X_W'(1);
                    end else begin
                        x  <= '0;
                        px <= ~px;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/best_arr_sender.sv
// Output stage: streams the best-index RAM into the output FIFO in blocked order.
// A 2-entry skid absorbs the RAM read latency so backpressure never drops a word.
module best_arr_sender
    import fann_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    best_arr_sender_if.master bus
);
    sender_state_t         state;
    idx_t                  skid_data [2];
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [1:0]            count;
    logic                  inflight;
    logic                  issue;
    logic                  pop;
    logic [2:0]            occupancy_next;
    logic                  gen_last;
    logic [ADDR_WIDTH-1:0] gen_addr;

    blocked_addr_gen u_addr_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (issue),
        .addr  (gen_addr),
        .last  (gen_last)
    );

    // A read is issued only if the word returning next cycle is sure to find a free slot;
    // the first read goes out on the start pulse itself to save a cycle of latency.
    always_comb begin
        pop            = (count != 2'd0) && bus.out_fifo_wfull_n;
        occupancy_next = 3'(count) + 3'(inflight) - 3'(pop);
        issue          = 1'b0;
        case (state)
            IDLE:    issue = bus.send_best_arr;
            RUN:     issue = (occupancy_next < 3'd2);
            default: issue = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (bus.send_best_arr) state <= RUN;
                RUN:     if (issue && gen_last) state <= DRAIN;
                DRAIN:   if (count == 2'd0 && !inflight) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_data[0] <= '0;
            skid_data[1] <= '0;
            rd_ptr       <= 1'b0;
            wr_ptr       <= 1'b0;
            count        <= 2'd0;
            inflight     <= 1'b0;
        end else begin
            inflight <= issue;
            if (inflight) begin
                skid_data[wr_ptr] <= bus.ram_rdata;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(inflight) - 2'(pop);
        end
    end

    assign bus.ram_csb        = ~issue;
    assign bus.ram_addr       = gen_addr;
    assign bus.out_fifo_wenq  = pop;
    assign bus.out_fifo_wdata = skid_data[rd_ptr];
    assign bus.busy           = (state != IDLE);
    assign bus.done           = (state == DRAIN) && (count == 2'd0) && !inflight;

endmodule
